// File: rtl/cache_flush_walker.sv
// Flush walker: visits all 8 cache sets, writes back valid+dirty lines, then clears their dirty bits.
// Optional FLUSH_INVALIDATE_EN: also invalidates every valid line during the walk.
module cache_flush_walker #(
  parameter int width     = 256,
  parameter int tag_width = 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush_req,
  output logic                 busy,
  output logic                 flush_done,
  output logic [2:0]           arr_rindex,
  output logic [2:0]           arr_windex,
  input  logic                 valid_dataout,
  input  logic                 dirty_dataout,
  input  logic [tag_width-1:0] tag_dataout,
  input  logic [width-1:0]     data_dataout,
  output logic                 dirty_load,
  output logic                 valid_load,
  output logic [31:0]          mem_address,
  output logic [width-1:0]     mem_wdata,
  output logic                 mem_write,
  input  logic                 mem_resp
);
  localparam int s_offset = $clog2(width/8);

  typedef enum logic [2:0] {IDLE, SCAN, WRITE, CLEAR, DONE} state_t;

  state_t           state_q, state_d;
  logic [2:0]       idx_q, idx_d;
  logic [31:0]      addr_q;
  logic [width-1:0] data_q;
  logic             cap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      if (cap) begin
        addr_q <= {tag_dataout, idx_q, {s_offset{1'b0}}};
        data_q <= data_dataout;
      end
    end
  end

  // idx only advances from SCAN/CLEAR and saturates at 7, so the walk always ends in DONE
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cap     = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush_req) begin
          idx_d   = 3'd0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (valid_dataout && dirty_dataout) begin
          cap     = 1'b1;
          state_d = WRITE;
        end
`ifdef FLUSH_INVALIDATE_EN
        else if (valid_dataout) state_d = CLEAR;
`endif
        else if (idx_q == 3'd7) state_d = DONE;
        else idx_d = idx_q + 3'd1;
      end
      WRITE: begin
        if (mem_resp) state_d = CLEAR;
      end
      CLEAR: begin
        if (idx_q == 3'd7) state_d = DONE;
        else begin
          idx_d   = idx_q + 3'd1;
          state_d = SCAN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy        = (state_q != IDLE);
  assign flush_done  = (state_q == DONE);
  assign mem_write   = (state_q == WRITE);
  assign dirty_load  = (state_q == CLEAR);
`ifdef FLUSH_INVALIDATE_EN
  assign valid_load  = (state_q == CLEAR);
`else
  assign valid_load  = 1'b0;
`endif
  assign arr_rindex  = idx_q;
  assign arr_windex  = idx_q;
  assign mem_address = addr_q;
  assign mem_wdata   = data_q;
endmodule
